// File: rtl/draw_cmd_parser_pkg.sv
// Shared opcodes, parser states and payload-length helpers for the draw command parser.
package draw_cmd_pkg;

    localparam logic [7:0] OPC_RECT = 8'h52;
    localparam logic [7:0] OPC_BASE = 8'h42;

    typedef enum logic [1:0] {
        ST_OPC,
        ST_ARGS,
        ST_CLIP,
        ST_ISSUE
    } state_t;

    // x, y, w, h (16 bits each) followed by the color bytes
    function automatic int unsigned rect_len(input int unsigned bytes_per_pix);
        return 8 + bytes_per_pix;
    endfunction

    function automatic int unsigned base_len(input int unsigned axi_addr_width);
        return axi_addr_width / 8;
    endfunction

endpackage

// File: rtl/draw_cmd_parser_if.sv
// Byte-stream input and drawer request port of the draw command parser.
interface draw_cmd_parser_if #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned PIX_WIDTH      = 32
) ();
    logic [7:0]                in_data;
    logic                      in_valid;
    logic                      in_ready;
    logic [AXI_ADDR_WIDTH-1:0] req_base_addr;
    logic [15:0]               req_x;
    logic [15:0]               req_y;
    logic [15:0]               req_w;
    logic [15:0]               req_h;
    logic [PIX_WIDTH-1:0]      req_color;
    logic                      req_valid;
    logic                      req_ready;
    logic [7:0]                drop_count;

    modport master (
        input  in_data, in_valid, req_ready,
        output in_ready, req_base_addr, req_x, req_y, req_w, req_h,
               req_color, req_valid, drop_count
    );

    modport slave (
        output in_data, in_valid, req_ready,
        input  in_ready, req_base_addr, req_x, req_y, req_w, req_h,
               req_color, req_valid, drop_count
    );
endinterface

// File: rtl/draw_cmd_parser_rect_clip.sv
// Combinational rectangle reject test and clipping of width/height to the framebuffer.
module rect_clip #(
    parameter int unsigned IMG_WIDTH  = 1920,
    parameter int unsigned IMG_HEIGHT = 1080
) (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic [15:0] w,
    input  logic [15:0] h,
    output logic        reject_c,
    output logic [15:0] w_c,
    output logic [15:0] h_c
);
    logic [16:0] room_w;
    logic [16:0] room_h;

    // 17-bit arithmetic so a full 16-bit w/h never wraps against the remaining room
    always_comb begin
        room_w   = 17'(IMG_WIDTH)  - {1'b0, x};
        room_h   = 17'(IMG_HEIGHT) - {1'b0, y};
        reject_c = ({1'b0, x} >= 17'(IMG_WIDTH)) || ({1'b0, y} >= 17'(IMG_HEIGHT)) ||
                   (w == 16'd0) || (h == 16'd0);
        w_c      = ({1'b0, w} < room_w) ? w : room_w[15:0];
        h_c      = ({1'b0, h} < room_h) ? h : room_h[15:0];
    end
endmodule

// File: rtl/draw_cmd_parser.sv
// Assembles RECT/BASE commands from a byte stream, clips rectangles and issues drawer requests.
import draw_cmd_pkg::*;

module draw_cmd_parser #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned IMG_WIDTH      = 1920,
    parameter int unsigned IMG_HEIGHT     = 1080,
    parameter int unsigned BYTES_PER_PIX  = 4,
    parameter int unsigned PIX_WIDTH      = BYTES_PER_PIX * 8
) (
    input  logic              clk,
    input  logic              rst,
    draw_cmd_parser_if.master bus
);
    localparam int unsigned RECT_LEN  = rect_len(BYTES_PER_PIX);
    localparam int unsigned BASE_LEN  = base_len(AXI_ADDR_WIDTH);
    localparam int unsigned SHIFT_LEN = (RECT_LEN > BASE_LEN) ? RECT_LEN : BASE_LEN;
    localparam int unsigned SHIFT_W   = SHIFT_LEN * 8;
    localparam int unsigned RECT_OFF  = (SHIFT_LEN - RECT_LEN) * 8;
    localparam int unsigned CNT_W     = 8;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      is_rect_q, is_rect_d;
    logic [SHIFT_W-1:0]        shift_q, shift_d;
    logic                      in_ready_q, in_ready_d;
    logic                      req_valid_q, req_valid_d;
    logic [AXI_ADDR_WIDTH-1:0] base_q, base_d;
    logic [15:0]               x_q, x_d, y_q, y_d, w_q, w_d, h_q, h_d;
    logic [PIX_WIDTH-1:0]      color_q, color_d;
    logic [7:0]                drop_q, drop_d;

    logic                      accept;
    logic [15:0]               rx, ry, rw, rh;
    logic                      reject_c;
    logic [15:0]               clip_w_c, clip_h_c;

    // Bytes shift in from the top, so a complete packet ends up LSB-first at the bottom
    assign rx     = shift_q[RECT_OFF      +: 16];
    assign ry     = shift_q[RECT_OFF + 16 +: 16];
    assign rw     = shift_q[RECT_OFF + 32 +: 16];
    assign rh     = shift_q[RECT_OFF + 48 +: 16];
    assign accept = bus.in_valid && in_ready_q;

    rect_clip #(
        .IMG_WIDTH  (IMG_WIDTH),
        .IMG_HEIGHT (IMG_HEIGHT)
    ) u_clip (
        .x        (rx),
        .y        (ry),
        .w        (rw),
        .h        (rh),
        .reject_c (reject_c),
        .w_c      (clip_w_c),
        .h_c      (clip_h_c)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_rect_d = is_rect_q;
        shift_d   = shift_q;
        base_d    = base_q;
        x_d       = x_q;
        y_d       = y_q;
        w_d       = w_q;
        h_d       = h_q;
        color_d   = color_q;
        drop_d    = drop_q;

        case (state_q)
            ST_OPC: begin
                if (accept) begin
                    if (bus.in_data == OPC_RECT) begin
                        state_d   = ST_ARGS;
                        cnt_d     = CNT_W'(RECT_LEN);
                        is_rect_d = 1'b1;
                    end else if (bus.in_data == OPC_BASE) begin
                        state_d   = ST_ARGS;
                        cnt_d     = CNT_W'(BASE_LEN);
                        is_rect_d = 1'b0;
                    end else if (drop_q != 8'hFF) begin
                        drop_d = drop_q + 8'd1;
                    end
                end
            end
            ST_ARGS: begin
                if (accept) begin
                    shift_d = {bus.in_data, shift_q[SHIFT_W-1:8]};
                    cnt_d   = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        if (is_rect_q) begin
                            state_d = ST_CLIP;
                        end else begin
                            base_d  = shift_d[SHIFT_W-1 -: AXI_ADDR_WIDTH];
                            state_d = ST_OPC;
                        end
                    end
                end
            end
            ST_CLIP: begin
                if (reject_c) begin
                    if (drop_q != 8'hFF) begin
                        drop_d = drop_q + 8'd1;
                    end
                    state_d = ST_OPC;
                end else begin
                    x_d     = rx;
                    y_d     = ry;
                    w_d     = clip_w_c;
                    h_d     = clip_h_c;
                    color_d = shift_q[RECT_OFF + 64 +: PIX_WIDTH];
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (bus.req_ready) begin
                    state_d = ST_OPC;
                end
            end
            default: state_d = ST_OPC;
        endcase

        // Handshake flags are registered decodes of the next state
        in_ready_d  = (state_d == ST_OPC) || (state_d == ST_ARGS);
        req_valid_d = (state_d == ST_ISSUE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_OPC;
            cnt_q       <= '0;
            is_rect_q   <= 1'b0;
            shift_q     <= '0;
            in_ready_q  <= 1'b0;
            req_valid_q <= 1'b0;
            base_q      <= '0;
            x_q         <= '0;
            y_q         <= '0;
            w_q         <= '0;
            h_q         <= '0;
            color_q     <= '0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_rect_q   <= is_rect_d;
            shift_q     <= shift_d;
            in_ready_q  <= in_ready_d;
            req_valid_q <= req_valid_d;
            base_q      <= base_d;
            x_q         <= x_d;
            y_q         <= y_d;
            w_q         <= w_d;
            h_q         <= h_d;
            color_q     <= color_d;
            drop_q      <= drop_d;
        end
    end

    assign bus.in_ready      = in_ready_q;
    assign bus.req_valid     = req_valid_q;
    assign bus.req_base_addr = base_q;
    assign bus.req_x         = x_q;
    assign bus.req_y         = y_q;
    assign bus.req_w         = w_q;
    assign bus.req_h         = h_q;
    assign bus.req_color     = color_q;
    assign bus.drop_count    = drop_q;
endmodule

// File: tb/tb_draw_cmd_parser.sv
// Self-checking bench for draw_cmd_parser: vector table plus scoreboard of expected requests.
module tb_draw_cmd_parser;
    logic clk = 1'b0;
    logic rst = 1'b1;

    draw_cmd_parser_if #(.AXI_ADDR_WIDTH(32), .PIX_WIDTH(32)) bus ();

    draw_cmd_parser #(
        .AXI_ADDR_WIDTH (32),
        .IMG_WIDTH      (1920),
        .IMG_HEIGHT     (1080),
        .BYTES_PER_PIX  (4),
        .PIX_WIDTH      (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] x, y, w, h;
        logic [31:0] color;
        logic [31:0] base;
    } exp_t;

    typedef struct {
        logic [15:0] x, y, w, h;
        logic [31:0] color;
        bit          issue;
        logic [15:0] ew, eh;
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic [31:0] cur_base = 32'd0;
    int   exp_drop = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard pops on each handshake; stalled requests must hold steady
    logic        p_valid, p_ready;
    logic [15:0] p_x, p_y, p_w, p_h;
    logic [31:0] p_color, p_base;
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (p_valid && !p_ready) begin
                chk("stall_valid", 64'(bus.req_valid), 64'(1));
                chk("stall_fields", {bus.req_x, bus.req_y, bus.req_w, bus.req_h},
                    {p_x, p_y, p_w, p_h});
                chk("stall_color_base", {bus.req_color, bus.req_base_addr}, {p_color, p_base});
            end
            if (bus.req_valid && bus.req_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_req", 64'(1), 64'(0));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("req_xywh", {bus.req_x, bus.req_y, bus.req_w, bus.req_h},
                        {e.x, e.y, e.w, e.h});
                    chk("req_color_base", {bus.req_color, bus.req_base_addr}, {e.color, e.base});
                end
            end
        end
        p_valid = bus.req_valid && !rst;
        p_ready = bus.req_ready;
        p_x = bus.req_x; p_y = bus.req_y; p_w = bus.req_w; p_h = bus.req_h;
        p_color = bus.req_color; p_base = bus.req_base_addr;
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("in_ready_timeout", 64'(0), 64'(1));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_rect(input logic [15:0] x, y, w, h, input logic [31:0] c);
        send_byte(8'h52);
        send_byte(x[7:0]); send_byte(x[15:8]);
        send_byte(y[7:0]); send_byte(y[15:8]);
        send_byte(w[7:0]); send_byte(w[15:8]);
        send_byte(h[7:0]); send_byte(h[15:8]);
        send_byte(c[7:0]); send_byte(c[15:8]); send_byte(c[23:16]); send_byte(c[31:24]);
    endtask

    task automatic push_exp(input logic [15:0] x, y, w, h, input logic [31:0] c);
        exp_t e;
        e.x = x; e.y = y; e.w = w; e.h = h; e.color = c; e.base = cur_base;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{16'd10,    16'd20,   16'd100,   16'd50,    32'h00FF00FF, 1'b1, 16'd100,  16'd50};
        vecs[1]  = '{16'd1900,  16'd1070, 16'd100,   16'd100,   32'h12345678, 1'b1, 16'd20,   16'd10};
        vecs[2]  = '{16'd1920,  16'd0,    16'd5,     16'd5,     32'h0,        1'b0, 16'd0,    16'd0};
        vecs[3]  = '{16'd0,     16'd0,    16'd0,     16'd5,     32'h0,        1'b0, 16'd0,    16'd0};
        vecs[4]  = '{16'd0,     16'd0,    16'd5,     16'd0,     32'h0,        1'b0, 16'd0,    16'd0};
        vecs[5]  = '{16'd0,     16'd1080, 16'd5,     16'd5,     32'h0,        1'b0, 16'd0,    16'd0};
        vecs[6]  = '{16'd1919,  16'd1079, 16'd1,     16'd1,     32'hDEADBEEF, 1'b1, 16'd1,    16'd1};
        vecs[7]  = '{16'd0,     16'd0,    16'd1920,  16'd1080,  32'hA5A5A5A5, 1'b1, 16'd1920, 16'd1080};
        vecs[8]  = '{16'd0,     16'd0,    16'hFFFF,  16'hFFFF,  32'h01020304, 1'b1, 16'd1920, 16'd1080};
        vecs[9]  = '{16'd1000,  16'd500,  16'hFFFF,  16'd1,     32'hCAFEF00D, 1'b1, 16'd920,  16'd1};
        vecs[10] = '{16'hFFFF,  16'd0,    16'd1,     16'd1,     32'h0,        1'b0, 16'd0,    16'd0};

        bus.in_data   = 8'h00;
        bus.in_valid  = 1'b0;
        bus.req_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", 64'(bus.in_ready), 64'(0));
        chk("reset_req_valid", 64'(bus.req_valid), 64'(0));
        chk("reset_drop", 64'(bus.drop_count), 64'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("first_in_ready", 64'(bus.in_ready), 64'(1));
        mon_en = 1'b1;

        // Latency and single-cycle pulse with req_ready tied high
        push_exp(16'd10, 16'd20, 16'd100, 16'd50, 32'h00FF00FF);
        send_rect(16'd10, 16'd20, 16'd100, 16'd50, 32'h00FF00FF);
        chk("lat_clip_valid", 64'(bus.req_valid), 64'(0));
        chk("lat_clip_in_ready", 64'(bus.in_ready), 64'(0));
        idle(1);
        chk("lat_issue_valid", 64'(bus.req_valid), 64'(1));
        idle(1);
        chk("lat_after_valid", 64'(bus.req_valid), 64'(0));
        chk("lat_after_in_ready", 64'(bus.in_ready), 64'(1));

        for (int i = 0; i < 11; i++) begin
            if (vecs[i].issue) push_exp(vecs[i].x, vecs[i].y, vecs[i].ew, vecs[i].eh, vecs[i].color);
            else exp_drop++;
            send_rect(vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].h, vecs[i].color);
            idle(4);
            chk("vec_drop", 64'(bus.drop_count), 64'(exp_drop));
        end
        send_byte(8'h7F);
        exp_drop++;
        chk("unknown_drop", 64'(bus.drop_count), 64'(exp_drop));

        // BASE then a stalled request: fields hold, no bytes consumed
        bus.req_ready = 1'b0;
        send_byte(8'h42);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
        cur_base = 32'h1000_0000;
        chk("base_now", 64'(bus.req_base_addr), 64'(32'h1000_0000));
        push_exp(16'd300, 16'd400, 16'd64, 16'd32, 32'h55AA55AA);
        send_rect(16'd300, 16'd400, 16'd64, 16'd32, 32'h55AA55AA);
        begin
            int n;
            n = 0;
            while (!bus.req_valid && n < 20) begin
                idle(1);
                n++;
            end
            chk("stall_req_seen", 64'(bus.req_valid), 64'(1));
        end
        bus.in_data  = 8'h7F;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            idle(1);
            chk("stall_hold_valid", 64'(bus.req_valid), 64'(1));
            chk("stall_in_ready", 64'(bus.in_ready), 64'(0));
            chk("stall_no_consume", 64'(bus.drop_count), 64'(exp_drop));
        end
        bus.req_ready = 1'b1;
        send_byte(8'h7F);
        exp_drop++;
        idle(1);
        chk("post_stall_drop", 64'(bus.drop_count), 64'(exp_drop));
        chk("post_stall_valid", 64'(bus.req_valid), 64'(0));

        // Reset mid-packet discards the partial rectangle
        send_byte(8'h52);
        send_byte(8'd5); send_byte(8'd0); send_byte(8'd6); send_byte(8'd0);
        rst = 1'b1;
        idle(2);
        chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
        chk("rst_valid", 64'(bus.req_valid), 64'(0));
        chk("rst_fields", {bus.req_x, bus.req_y, bus.req_w, bus.req_h}, 64'(0));
        chk("rst_color_base", {bus.req_color, bus.req_base_addr}, 64'(0));
        chk("rst_drop", 64'(bus.drop_count), 64'(0));
        rst = 1'b0;
        cur_base = 32'd0;
        exp_drop = 0;
        idle(1);
        chk("rst_release_in_ready", 64'(bus.in_ready), 64'(1));
        push_exp(16'd7, 16'd8, 16'd9, 16'd10, 32'h0BADC0DE);
        send_rect(16'd7, 16'd8, 16'd9, 16'd10, 32'h0BADC0DE);
        idle(4);

        // Saturating drop counter
        for (int i = 0; i < 300; i++) send_byte(8'h7F);
        idle(1);
        chk("drop_saturate", 64'(bus.drop_count), 64'(255));

        idle(2);
        chk("sb_empty", 64'(sb.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
